// File: rtl/mem_stage_pkg.sv
// rtl/mem_stage_pkg.sv - shared types and helpers for the memory stage
package mem_stage_pkg;

  typedef enum logic [1:0] {REG_DMEM, REG_IMG, REG_NONE} region_t;
  typedef enum logic [0:0] {IDLE, IMG_WAIT} mstate_t;

  localparam int MAX_IMG_LAT = 8;

  // Latency counter must hold IMG_LAT-1 for any legal latency.
  function automatic int cnt_width(input int lat);
    return (lat < 2) ? 1 : $clog2(lat + 1);
  endfunction

endpackage

// File: rtl/memory_stage_gen_region_decode.sv
// rtl/memory_stage_gen_region_decode.sv - address to region/index decode
module mem_region_decode
  import mem_stage_pkg::*;
#(
  parameter int ADDR_W     = 22,
  parameter int DMEM_BASE  = 0,
  parameter int DMEM_DEPTH = 1024,
  parameter int IMG_BASE   = 'h010000,
  parameter int IMG_DEPTH  = 65536,
  localparam int DIW = $clog2(DMEM_DEPTH),
  localparam int IIW = $clog2(IMG_DEPTH)
) (
  input  logic [ADDR_W-1:0] addr_i,
  output region_t           region_o,
  output logic [DIW-1:0]    dmem_idx_o,
  output logic [IIW-1:0]    img_idx_o
);

  // One extra bit catches the borrow when addr is below the base.
  logic [ADDR_W:0] d_off;
  logic [ADDR_W:0] i_off;
  logic            in_dmem;
  logic            in_img;

  assign d_off   = {1'b0, addr_i} - (ADDR_W+1)'(DMEM_BASE);
  assign i_off   = {1'b0, addr_i} - (ADDR_W+1)'(IMG_BASE);
  assign in_dmem = !d_off[ADDR_W] && (d_off < (ADDR_W+1)'(DMEM_DEPTH));
  assign in_img  = !i_off[ADDR_W] && (i_off < (ADDR_W+1)'(IMG_DEPTH));

  assign dmem_idx_o = d_off[DIW-1:0];
  assign img_idx_o  = i_off[IIW-1:0];

  always_comb begin
    if (in_dmem)     region_o = REG_DMEM;
    else if (in_img) region_o = REG_IMG;
    else             region_o = REG_NONE;
  end

endmodule

// File: rtl/memory_stage_gen.sv
// rtl/memory_stage_gen.sv - memory stage with data memory and multi-cycle image memory
module memory_stage_gen
  import mem_stage_pkg::*;
#(
  parameter int DATA_W     = 22,
  parameter int ADDR_W     = 22,
  parameter int IMG_W      = 8,
  parameter int DMEM_BASE  = 0,
  parameter int DMEM_DEPTH = 1024,
  parameter int IMG_BASE   = 'h010000,
  parameter int IMG_DEPTH  = 65536,
  parameter int IMG_LAT    = 3
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req_valid,
  input  logic              req_write,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [DATA_W-1:0] req_wdata,
  output logic              stall_m,
  output logic              rd_valid,
  output logic [DATA_W-1:0] rd_data,
  output logic              addr_err
);

  localparam int DIW = $clog2(DMEM_DEPTH);
  localparam int IIW = $clog2(IMG_DEPTH);
  localparam int CW  = cnt_width(IMG_LAT);

  logic [DATA_W-1:0] dmem [DMEM_DEPTH];
  logic [IMG_W-1:0]  imem [IMG_DEPTH];

  region_t           region;
  logic [DIW-1:0]    didx;
  logic [IIW-1:0]    iidx;
  logic              accept;

  mstate_t           state_q, state_d;
  logic [CW-1:0]     cnt_q, cnt_d;
  logic              rd_valid_q, rd_valid_d;
  logic [DATA_W-1:0] rd_data_q, rd_data_d;
  logic              addr_err_q, addr_err_d;
  logic [IMG_W-1:0]  pix_q, pix_d;

  mem_region_decode #(
    .ADDR_W     (ADDR_W),
    .DMEM_BASE  (DMEM_BASE),
    .DMEM_DEPTH (DMEM_DEPTH),
    .IMG_BASE   (IMG_BASE),
    .IMG_DEPTH  (IMG_DEPTH)
  ) u_decode (
    .addr_i     (req_addr),
    .region_o   (region),
    .dmem_idx_o (didx),
    .img_idx_o  (iidx)
  );

  assign stall_m  = (state_q == IMG_WAIT);
  assign accept   = req_valid && !stall_m;
  assign rd_valid = rd_valid_q;
  assign rd_data  = rd_data_q;
  assign addr_err = addr_err_q;

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    rd_valid_d = 1'b0;
    rd_data_d  = rd_data_q;
    addr_err_d = 1'b0;
    pix_d      = pix_q;
    case (state_q)
      IDLE: begin
        if (accept) begin
          case (region)
            REG_DMEM: begin
              if (!req_write) begin
                rd_valid_d = 1'b1;
                rd_data_d  = dmem[didx];
              end
            end
            REG_IMG: begin
              if (!req_write) begin
                if (IMG_LAT == 1) begin
                  rd_valid_d = 1'b1;
                  rd_data_d  = DATA_W'(imem[iidx]);
                end else begin
                  // Pixel is captured now; stores cannot land while stalled.
                  state_d = IMG_WAIT;
                  cnt_d   = CW'(IMG_LAT - 1);
                  pix_d   = imem[iidx];
                end
              end
            end
            default: begin
              addr_err_d = 1'b1;
              if (!req_write) begin
                rd_valid_d = 1'b1;
                rd_data_d  = '0;
              end
            end
          endcase
        end
      end
      IMG_WAIT: begin
        if (cnt_q == CW'(1)) begin
          state_d    = IDLE;
          rd_valid_d = 1'b1;
          rd_data_d  = DATA_W'(pix_q);
        end else begin
          cnt_d = cnt_q - CW'(1);
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      cnt_q      <= '0;
      rd_valid_q <= 1'b0;
      rd_data_q  <= '0;
      addr_err_q <= 1'b0;
      pix_q      <= '0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      rd_valid_q <= rd_valid_d;
      rd_data_q  <= rd_data_d;
      addr_err_q <= addr_err_d;
      pix_q      <= pix_d;
    end
  end

  always_ff @(posedge clk) begin
    if (rst_n && accept && req_write) begin
      if (region == REG_DMEM) dmem[didx] <= req_wdata;
      if (region == REG_IMG)  imem[iidx] <= req_wdata[IMG_W-1:0];
    end
  end

endmodule
